// File: rtl/csi2_raw10_tx_packer_pkg.sv
// Shared CSI-2 TX definitions: data types, FSM states, ECC and CRC-16 helpers.
// Used by csi2_raw10_tx_packer and csi2_crc16.
package csi2_pkg;

    localparam logic [5:0] DT_FS    = 6'h00;
    localparam logic [5:0] DT_FE    = 6'h01;
    localparam logic [5:0] DT_RAW10 = 6'h2B;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHDR,
        ST_LHDR,
        ST_PAYLOAD,
        ST_FOOTER
    } state_e;

    // Hamming parity over {WC[15:0], DI[7:0]}
    function automatic logic [5:0] csi2_ecc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10] ^ d[11]
             ^ d[13] ^ d[16] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
        p[1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[12]
             ^ d[14] ^ d[17] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
        p[2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[11] ^ d[12]
             ^ d[15] ^ d[18] ^ d[20] ^ d[21] ^ d[22];
        p[3] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[13] ^ d[14]
             ^ d[15] ^ d[19] ^ d[20] ^ d[21] ^ d[23];
        p[4] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[16] ^ d[17]
             ^ d[18] ^ d[19] ^ d[20] ^ d[22] ^ d[23];
        p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16]
             ^ d[17] ^ d[18] ^ d[19] ^ d[21] ^ d[22] ^ d[23];
        return p;
    endfunction

    // Reflected x^16+x^12+x^5+1 (0x8408), one byte LSB-first
    function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                               input logic [7:0]  b);
        logic [15:0] c;
        c = crc ^ {8'h00, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/csi2_raw10_tx_packer_if.sv
// Pixel-in / byte-out handshake bundle of the CSI-2 RAW10 TX packer.
// master = pixel source and byte sink side, slave = packer side.
interface csi2_tx_if (
    input logic clk
);
    logic       pix_valid;
    logic       pix_ready;
    logic [9:0] pix_data;
    logic       byte_valid;
    logic       byte_ready;
    logic [7:0] byte_data;
    logic       sop;
    logic       eop;

    modport master (
        input  clk,
        output pix_valid, pix_data, byte_ready,
        input  pix_ready, byte_valid, byte_data, sop, eop
    );

    modport slave (
        input  clk,
        input  pix_valid, pix_data, byte_ready,
        output pix_ready, byte_valid, byte_data, sop, eop
    );
endinterface

// File: rtl/csi2_raw10_tx_packer_crc16.sv
// Byte-wide CRC-16 accumulator (init 0xFFFF, reflected 0x8408, no final XOR).
// init_i has priority over en_i.
module csi2_crc16
    import csi2_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init_i,
    input  logic        en_i,
    input  logic [7:0]  data_i,
    output logic [15:0] crc_o
);
    logic [15:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (init_i) begin
            crc_d = 16'hFFFF;
        end else if (en_i) begin
            crc_d = crc16_step(crc_q, data_i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= 16'hFFFF;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;
endmodule

// File: rtl/csi2_raw10_tx_packer.sv
// RAW10 pixel stream -> CSI-2 byte stream with FS/FE short packets.
// Define CSI2_TX_CRC_EN to compute the footer CRC-16 (else footer is 00 00).
module csi2_raw10_tx_packer
    import csi2_pkg::*;
#(
    parameter int         LINE_PIXELS = 640,
    parameter logic [1:0] VC          = 2'd0
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        fs_i,
    input  logic        fe_i,
    input  logic        pix_valid_i,
    output logic        pix_ready_o,
    input  logic [9:0]  pix_data_i,
    output logic        byte_valid_o,
    input  logic        byte_ready_i,
    output logic [7:0]  byte_data_o,
    output logic        sop_o,
    output logic        eop_o,
    output logic        busy_o,
    output logic [15:0] frame_num_o
);
    localparam int            PW = $clog2(LINE_PIXELS + 1);
    localparam logic [PW-1:0] LP = PW'(LINE_PIXELS);
    localparam logic [15:0]   WC = 16'(LINE_PIXELS * 5 / 4);

    state_e        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [2:0]    phase_q, phase_d;
    logic [PW-1:0] pix_cnt_q, pix_cnt_d;
    logic [7:0]    lsb_q, lsb_d;
    logic          is_fe_q, is_fe_d;
    logic          fs_pend_q, fs_pend_d;
    logic          fe_pend_q, fe_pend_d;
    logic [15:0]   frame_num_q, frame_num_d;
    logic          byte_valid_q, byte_valid_d;
    logic [7:0]    byte_data_q, byte_data_d;
    logic          sop_q, sop_d;
    logic          eop_q, eop_d;

    logic          slot_free, pix_ready, ld, ld_sop, ld_eop;
    logic          crc_init, crc_en, fs_clr, fe_clr;
    logic [7:0]    ld_data, hdr_di, hdr_byte;
    logic [15:0]   hdr_wc, crc_val;
    logic [5:0]    hdr_ecc;

    // Header bytes for whichever header state is active
    always_comb begin
        hdr_di = {VC, is_fe_q ? DT_FE : DT_FS};
        hdr_wc = frame_num_q;
        if (state_q == ST_LHDR) begin
            hdr_di = {VC, DT_RAW10};
            hdr_wc = WC;
        end
        hdr_ecc = csi2_ecc({hdr_wc, hdr_di});
        unique case (cnt_q)
            2'd0:    hdr_byte = hdr_di;
            2'd1:    hdr_byte = hdr_wc[7:0];
            2'd2:    hdr_byte = hdr_wc[15:8];
            default: hdr_byte = {2'b00, hdr_ecc};
        endcase
    end

    assign slot_free = !byte_valid_q || byte_ready_i;
    assign pix_ready = (state_q == ST_PAYLOAD) && (phase_q != 3'd4)
                     && slot_free && (pix_cnt_q < LP);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        phase_d      = phase_q;
        pix_cnt_d    = pix_cnt_q;
        lsb_d        = lsb_q;
        is_fe_d      = is_fe_q;
        frame_num_d  = frame_num_q;
        byte_valid_d = byte_valid_q && !byte_ready_i;
        byte_data_d  = byte_data_q;
        sop_d        = sop_q;
        eop_d        = eop_q;
        ld           = 1'b0;
        ld_sop       = 1'b0;
        ld_eop       = 1'b0;
        ld_data      = 8'h00;
        crc_init     = 1'b0;
        crc_en       = 1'b0;
        fs_clr       = 1'b0;
        fe_clr       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = 2'd0;
                if (fs_pend_q) begin
                    state_d = ST_SHDR;
                    is_fe_d = 1'b0;
                    fs_clr  = 1'b1;
                end else if (fe_pend_q) begin
                    state_d = ST_SHDR;
                    is_fe_d = 1'b1;
                    fe_clr  = 1'b1;
                end else if (pix_valid_i) begin
                    state_d   = ST_LHDR;
                    phase_d   = 3'd0;
                    pix_cnt_d = '0;
                    crc_init  = 1'b1;
                end
            end
            ST_SHDR, ST_LHDR: begin
                if (slot_free) begin
                    ld      = 1'b1;
                    ld_data = hdr_byte;
                    ld_sop  = (cnt_q == 2'd0);
                    ld_eop  = (cnt_q == 2'd3) && (state_q == ST_SHDR);
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = (state_q == ST_SHDR) ? ST_IDLE : ST_PAYLOAD;
                        if (state_q == ST_SHDR && is_fe_q) begin
                            frame_num_d = (frame_num_q == 16'hFFFF) ?
                                          16'h0001 : frame_num_q + 16'h0001;
                        end
                    end
                end
            end
            ST_PAYLOAD: begin
                if (phase_q == 3'd4) begin
                    if (slot_free) begin
                        ld      = 1'b1;
                        crc_en  = 1'b1;
                        ld_data = lsb_q;
                        phase_d = 3'd0;
                        if (pix_cnt_q == LP) begin
                            state_d = ST_FOOTER;
                            cnt_d   = 2'd0;
                        end
                    end
                end else if (pix_ready && pix_valid_i) begin
                    ld        = 1'b1;
                    crc_en    = 1'b1;
                    ld_data   = pix_data_i[9:2];
                    lsb_d[{phase_q[1:0], 1'b0} +: 2] = pix_data_i[1:0];
                    phase_d   = phase_q + 3'd1;
                    pix_cnt_d = pix_cnt_q + 1'b1;
                end
            end
            ST_FOOTER: begin
                if (slot_free) begin
                    ld      = 1'b1;
                    ld_data = cnt_q[0] ? crc_val[15:8] : crc_val[7:0];
                    ld_eop  = cnt_q[0];
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q[0]) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (ld) begin
            byte_valid_d = 1'b1;
            byte_data_d  = ld_data;
            sop_d        = ld_sop;
            eop_d        = ld_eop;
        end

        // A pulse on the clearing cycle re-arms the flag
        fs_pend_d = (fs_pend_q && !fs_clr) || fs_i;
        fe_pend_d = (fe_pend_q && !fe_clr) || fe_i;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 2'd0;
            phase_q      <= 3'd0;
            pix_cnt_q    <= '0;
            lsb_q        <= 8'h00;
            is_fe_q      <= 1'b0;
            fs_pend_q    <= 1'b0;
            fe_pend_q    <= 1'b0;
            frame_num_q  <= 16'h0000;
            byte_valid_q <= 1'b0;
            byte_data_q  <= 8'h00;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            phase_q      <= phase_d;
            pix_cnt_q    <= pix_cnt_d;
            lsb_q        <= lsb_d;
            is_fe_q      <= is_fe_d;
            fs_pend_q    <= fs_pend_d;
            fe_pend_q    <= fe_pend_d;
            frame_num_q  <= frame_num_d;
            byte_valid_q <= byte_valid_d;
            byte_data_q  <= byte_data_d;
            sop_q        <= sop_d;
            eop_q        <= eop_d;
        end
    end

`ifdef CSI2_TX_CRC_EN
    csi2_crc16 u_crc (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .init_i (crc_init),
        .en_i   (crc_en),
        .data_i (ld_data),
        .crc_o  (crc_val)
    );
`else
    logic unused_crc;
    assign unused_crc = crc_init ^ crc_en;
    assign crc_val    = 16'h0000;
`endif

    assign pix_ready_o  = pix_ready;
    assign byte_valid_o = byte_valid_q;
    assign byte_data_o  = byte_data_q;
    assign sop_o        = sop_q;
    assign eop_o        = eop_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign frame_num_o  = frame_num_q;
endmodule

// File: tb/tb_csi2_raw10_tx_packer.sv
// Randomised self-checking bench for csi2_raw10_tx_packer: packet-level byte
// model with a per-byte compare process plus literal pins of known packets.
module tb_csi2_raw10_tx_packer;
    localparam int L   = 4;
    localparam int WCB = L * 5 / 4;
    localparam int NL  = 160;

    typedef logic [9:0] line_t [L];

    // ECC column of each data bit (parity set P5..P0 it participates in)
    localparam logic [5:0] ECC_COL [24] = '{
        6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
        6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
        6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fs  = 1'b0;
    logic        fe  = 1'b0;
    logic        busy;
    logic [15:0] frame;

    always #5 clk = ~clk;

    csi2_tx_if bus (.clk(clk));

    csi2_raw10_tx_packer #(.LINE_PIXELS(L), .VC(2'd0)) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .fs_i         (fs),
        .fe_i         (fe),
        .pix_valid_i  (bus.pix_valid),
        .pix_ready_o  (bus.pix_ready),
        .pix_data_i   (bus.pix_data),
        .byte_valid_o (bus.byte_valid),
        .byte_ready_i (bus.byte_ready),
        .byte_data_o  (bus.byte_data),
        .sop_o        (bus.sop),
        .eop_o        (bus.eop),
        .busy_o       (busy),
        .frame_num_o  (frame)
    );

    int          n_chk = 0;
    int          n_pass = 0;
    int          duty = 100;
    int          n_pix_sent = 0;
    int          n_pix_took = 0;
    logic        pix_take = 1'b0;
    logic [15:0] exp_frame = 16'h0000;
    logic [9:0]  exp_q [$];
    logic [9:0]  src_q [$];
    logic [7:0]  got_q [$];
    logic [7:0]  ref_q [$];
    line_t       lines [NL];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    function automatic logic [7:0] m_ecc(input logic [23:0] d);
        logic [5:0] e;
        e = 6'h00;
        for (int i = 0; i < 24; i++) if (d[i]) e ^= ECC_COL[i];
        return {2'b00, e};
    endfunction

    function automatic logic [15:0] m_crc(input logic [15:0] c,
                                          input logic [7:0] b);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ b[i];
            r  = r >> 1;
            if (fb) r ^= 16'h8408;
        end
        return r;
    endfunction

    task automatic push(input logic s, input logic e, input logic [7:0] d);
        exp_q.push_back({s, e, d});
    endtask

    task automatic push_short(input bit is_fe);
        logic [7:0] di;
        di = is_fe ? 8'h01 : 8'h00;
        push(1'b1, 1'b0, di);
        push(1'b0, 1'b0, exp_frame[7:0]);
        push(1'b0, 1'b0, exp_frame[15:8]);
        push(1'b0, 1'b1, m_ecc({exp_frame, di}));
        if (is_fe) exp_frame = (exp_frame == 16'hFFFF) ? 16'h0001 : exp_frame + 16'h1;
    endtask

    task automatic push_line(input line_t px);
        logic [7:0]  pl [$];
        logic [7:0]  lb;
        logic [15:0] crc;
        logic [15:0] wc;
        wc = 16'(WCB);
        push(1'b1, 1'b0, 8'h2B);
        push(1'b0, 1'b0, wc[7:0]);
        push(1'b0, 1'b0, wc[15:8]);
        push(1'b0, 1'b0, m_ecc({wc, 8'h2B}));
        for (int g = 0; g < L / 4; g++) begin
            lb = 8'h00;
            for (int k = 0; k < 4; k++) begin
                pl.push_back(8'(px[4*g+k] >> 2));
                lb = lb | (8'(px[4*g+k] % 4) << (2 * k));
            end
            pl.push_back(lb);
        end
        crc = 16'hFFFF;
        foreach (pl[i]) begin
            push(1'b0, 1'b0, pl[i]);
            crc = m_crc(crc, pl[i]);
        end
`ifndef CSI2_TX_CRC_EN
        crc = 16'h0000;
`endif
        push(1'b0, 1'b0, crc[7:0]);
        push(1'b0, 1'b1, crc[15:8]);
        foreach (px[i]) src_q.push_back(px[i]);
        n_pix_sent += L;
    endtask

    task automatic pulse(input logic f_s, input logic f_e);
        @(posedge clk); #1;
        fs = f_s;
        fe = f_e;
        @(posedge clk); #1;
        fs = 1'b0;
        fe = 1'b0;
    endtask

    task automatic drain(input string nm, input int lim);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy || bus.byte_valid) && t < lim) begin
            @(negedge clk);
            t++;
        end
        n_chk++;
        if (t < lim) n_pass++;
        else $display("FAIL %s_timeout: got %0d bytes outstanding want 0", nm, exp_q.size());
        chk({nm, "_pixels"}, n_pix_took, n_pix_sent);
    endtask

    task automatic wait_take(input int target);
        int t;
        t = 0;
        while (n_pix_took < target && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("take_wait", 32'(n_pix_took >= target), 32'd1);
    endtask

    // Compare bytes MSB-first in lit against the first n captured bytes
    task automatic chk_got(input string nm, input int n, input logic [127:0] lit);
        for (int i = 0; i < n; i++) begin
            if (i < got_q.size())
                chk($sformatf("%s_b%0d", nm, i), got_q[i], lit[8*(n-1-i) +: 8]);
            else
                chk($sformatf("%s_b%0d", nm, i), 32'hDEAD, lit[8*(n-1-i) +: 8]);
        end
    endtask

    // Pixel source and byte sink
    initial begin
        bus.pix_valid  = 1'b0;
        bus.pix_data   = 10'h000;
        bus.byte_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (pix_take && src_q.size() != 0) void'(src_q.pop_front());
            pix_take       = 1'b0;
            bus.pix_valid  = (src_q.size() != 0);
            bus.pix_data   = (src_q.size() != 0) ? src_q[0] : 10'h000;
            bus.byte_ready = ($urandom_range(99) < duty);
        end
    end

    // Compare process: every transferred byte and every stalled cycle
    initial begin
        logic       stall_prev;
        logic [9:0] held, e;
        stall_prev = 1'b0;
        held = 10'h000;
        forever begin
            @(negedge clk);
            pix_take = !rst && bus.pix_valid && bus.pix_ready;
            if (pix_take) n_pix_took++;
            if (!rst) begin
                if (bus.pix_ready) chk("ready_busy", busy, 1'b1);
                if (stall_prev)
                    chk("hold", {bus.byte_valid, bus.sop, bus.eop, bus.byte_data},
                        {1'b1, held});
                if (bus.byte_valid && bus.byte_ready) begin
                    got_q.push_back(bus.byte_data);
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL byte_extra: got %h want none", bus.byte_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("byte", {bus.sop, bus.eop, bus.byte_data}, e);
                    end
                end
                stall_prev = bus.byte_valid && !bus.byte_ready;
                held = {bus.sop, bus.eop, bus.byte_data};
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    initial begin
        line_t px;
        int    mism;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", bus.byte_valid, 1'b0);
        chk("rst_ready", bus.pix_ready, 1'b0);
        chk("rst_sop", bus.sop, 1'b0);
        chk("rst_eop", bus.eop, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_data", bus.byte_data, 8'h00);
        chk("rst_frame", frame, 16'h0000);
        @(posedge clk); #1;
        rst = 1'b0;

        got_q.delete();
        push_short(1'b0);
        pulse(1'b1, 1'b0);
        drain("fs", 200);
        chk_got("fs_lit", 4, 128'h00000000);
        chk("fs_frame", frame, 16'h0000);

        got_q.delete();
        push_short(1'b1);
        pulse(1'b0, 1'b1);
        drain("fe", 200);
        chk_got("fe_lit", 4, 128'h01000007);
        chk("fe_frame", frame, 16'h0001);

        got_q.delete();
        px = '{10'h3FF, 10'h001, 10'h2AA, 10'h155};
        push_line(px);
        drain("line", 200);
        chk("line_len", got_q.size(), 11);
        chk_got("line_lit", 9, 128'h2B05002EFF00AA5567);
`ifndef CSI2_TX_CRC_EN
        chk("line_ftr", {got_q[9], got_q[10]}, 16'h0000);
`endif

        for (int i = 0; i < NL; i++)
            for (int k = 0; k < L; k++) lines[i][k] = 10'($urandom);

        duty = 100;
        got_q.delete();
        for (int i = 0; i < NL; i++) push_line(lines[i]);
        drain("nostall", 20000);
        ref_q = got_q;

        duty = 30;
        got_q.delete();
        for (int i = 0; i < NL; i++) push_line(lines[i]);
        drain("stall", 40000);
        chk("stall_len", got_q.size(), ref_q.size());
        mism = 0;
        foreach (ref_q[i]) if (i >= got_q.size() || got_q[i] !== ref_q[i]) mism++;
        chk("stall_same", mism, 0);

        duty = 100;
        for (int k = 0; k < L; k++) px[k] = 10'($urandom);
        push_line(px);
        wait_take(n_pix_took + 1);
        push_short(1'b1);
        for (int k = 0; k < L; k++) px[k] = 10'($urandom);
        push_line(px);
        pulse(1'b0, 1'b1);
        drain("fe_mid", 500);
        chk("fe_mid_frame", frame, exp_frame);

        push_short(1'b0);
        push_short(1'b1);
        pulse(1'b1, 1'b1);
        drain("fsfe", 500);
        chk("fsfe_frame", frame, exp_frame);

        duty = 60;
        for (int k = 0; k < L; k++) px[k] = 10'($urandom);
        push_line(px);
        wait_take(n_pix_took + 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_valid", bus.byte_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        exp_q.delete();
        src_q.delete();
        n_pix_sent = n_pix_took;
        exp_frame = 16'h0000;
        @(posedge clk); #1;
        rst = 1'b0;
        got_q.delete();
        for (int k = 0; k < L; k++) px[k] = 10'($urandom);
        push_line(px);
        drain("after_rst", 500);
        chk("after_rst_len", got_q.size(), 11);

        @(negedge clk);
        force dut.frame_num_q = 16'hFFFF;
        @(negedge clk);
        release dut.frame_num_q;
        exp_frame = 16'hFFFF;
        got_q.delete();
        push_short(1'b1);
        pulse(1'b0, 1'b1);
        drain("wrap", 200);
        chk_got("wrap_lit", 3, 128'h01FFFF);
        chk("wrap_frame", frame, 16'h0001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "time limit");
    end
endmodule
